// File: rtl/mips_test_monitor.sv
// mips_test_monitor: checks core data-memory writes against an expected (addr,data)
//   table, ends the run with pass/fail, and drives scheduled interrupt pulses.
// Latency: pass/fail is visible one cycle after the deciding write or timeout cycle.
// Backpressure: none; the monitor only observes the write bus and never stalls the core.
// Ports: ph1/reset clock and synchronous reset; start, mode_any, strict, timeout,
//   check_en, exp_addr, exp_data, irq_at configure a run; memwrite, dataadr,
//   writedata are the core write bus; interrupts, busy, done, pass, fail, hits,
//   cycle_count report status.
module mips_test_monitor #(
  parameter int NUM_CHECKS = 4,
  parameter int NUM_IRQ    = 8,
  parameter int CNT_W      = 32,
  parameter int IRQ_WIDTH  = 5
) (
  input  logic                    ph1,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode_any,
  input  logic                    strict,
  input  logic [CNT_W-1:0]        timeout,
  input  logic [NUM_CHECKS-1:0]   check_en,
  input  logic [NUM_CHECKS*32-1:0] exp_addr,
  input  logic [NUM_CHECKS*32-1:0] exp_data,
  input  logic [NUM_IRQ*CNT_W-1:0] irq_at,
  input  logic                    memwrite,
  input  logic [31:0]             dataadr,
  input  logic [31:0]             writedata,
  output logic [NUM_IRQ-1:0]      interrupts,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic [NUM_CHECKS-1:0]   hits,
  output logic [CNT_W-1:0]        cycle_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;

  // Pulse width counter: loaded with IRQ_WIDTH-1 on the set edge, the line
  // drops on the edge where it has reached zero.
  localparam int                 IRQ_CW   = $clog2(IRQ_WIDTH + 1);
  localparam logic [IRQ_CW-1:0]  IRQ_LOAD = IRQ_CW'(IRQ_WIDTH - 1);

  state_t                             state_q, state_d;
  logic [NUM_CHECKS-1:0]              hits_q, hits_d;
  logic [CNT_W-1:0]                   cycle_count_q, cycle_count_d;
  logic [NUM_IRQ-1:0]                 interrupts_q, interrupts_d;
  logic [NUM_IRQ-1:0][IRQ_CW-1:0]     irq_cnt_q, irq_cnt_d;

  logic [NUM_CHECKS-1:0] avail;
  logic [NUM_CHECKS-1:0] ptr_oh;
  logic [NUM_CHECKS-1:0] addr_m;
  logic [NUM_CHECKS-1:0] data_m;
  logic [NUM_CHECKS-1:0] set_mask;
  logic                  strict_err;
  logic                  complete;

  // Per-entry address / data comparators shared by both matching modes.
  always_comb begin
    addr_m = '0;
    data_m = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      addr_m[i] = (dataadr == exp_addr[32*i +: 32]);
      data_m[i] = (writedata == exp_data[32*i +: 32]);
    end
  end

  // Entries still waiting for a write; the ordered pointer is the lowest one,
  // isolated as a one-hot mask with the x & -x trick.
  assign avail  = check_en & ~hits_q;
  assign ptr_oh = avail & (~avail + NUM_CHECKS'(1));

  always_comb begin
    set_mask   = '0;
    strict_err = 1'b0;
    if (state_q == ST_RUN && memwrite) begin
      if (mode_any) begin
        set_mask   = avail & addr_m & data_m;
        // Wrong data only if the address names some pending entry and no
        // pending entry at that address accepts the data.
        strict_err = (|(avail & addr_m)) && !(|set_mask);
      end else begin
        set_mask   = ptr_oh & addr_m & data_m;
        strict_err = |(ptr_oh & addr_m & ~data_m);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    hits_d        = hits_q;
    cycle_count_d = cycle_count_q;
    interrupts_d  = '0;
    irq_cnt_d     = irq_cnt_q;
    complete      = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        hits_d   = hits_q | set_mask;
        complete = &(hits_d | ~check_en);
        if (complete) begin
          state_d = ST_PASS;
        end else if (strict && strict_err) begin
          state_d = ST_FAIL;
        end else if (timeout != '0 && cycle_count_q == timeout) begin
          state_d = ST_FAIL;
        end else begin
          // Still running: count (saturating) and advance interrupt pulses.
          // Leaving RUN keeps the count frozen and drops every line.
          if (cycle_count_q != '1) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
          end
          for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_at[CNT_W*i +: CNT_W] != '0 &&
                cycle_count_q == irq_at[CNT_W*i +: CNT_W]) begin
              interrupts_d[i] = 1'b1;
              irq_cnt_d[i]    = IRQ_LOAD;
            end else if (interrupts_q[i] && irq_cnt_q[i] != '0) begin
              interrupts_d[i] = 1'b1;
              irq_cnt_d[i]    = irq_cnt_q[i] - IRQ_CW'(1);
            end
          end
        end
      end
      default: ;
    endcase

    // start restarts from any state, including mid-run.
    if (start) begin
      state_d       = ST_RUN;
      hits_d        = '0;
      cycle_count_d = '0;
      interrupts_d  = '0;
    end
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      hits_q        <= '0;
      cycle_count_q <= '0;
      interrupts_q  <= '0;
      irq_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      hits_q        <= hits_d;
      cycle_count_q <= cycle_count_d;
      interrupts_q  <= interrupts_d;
      irq_cnt_q     <= irq_cnt_d;
    end
  end

  assign interrupts  = interrupts_q;
  assign busy        = (state_q == ST_RUN);
  assign pass        = (state_q == ST_PASS);
  assign fail        = (state_q == ST_FAIL);
  assign done        = pass | fail;
  assign hits        = hits_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mips_test_monitor.sv
`timescale 1ns/1ps
module tb_mips_test_monitor;
  localparam int NC = 4;
  localparam int NI = 8;
  localparam int CW = 32;
  localparam int IW = 5;
  localparam longint unsigned CNT_MAX = (longint'(1) << CW) - 1;

  logic              ph1 = 1'b0;
  logic              reset, start, mode_any, strict, memwrite;
  logic [CW-1:0]     timeout;
  logic [NC-1:0]     check_en;
  logic [NC*32-1:0]  exp_addr, exp_data;
  logic [NI*CW-1:0]  irq_at;
  logic [31:0]       dataadr, writedata;
  logic [NI-1:0]     interrupts;
  logic              busy, done, pass, fail;
  logic [NC-1:0]     hits;
  logic [CW-1:0]     cycle_count;

  always #5 ph1 = ~ph1;

  mips_test_monitor #(.NUM_CHECKS(NC), .NUM_IRQ(NI), .CNT_W(CW), .IRQ_WIDTH(IW)) dut (
    .ph1(ph1), .reset(reset), .start(start), .mode_any(mode_any), .strict(strict),
    .timeout(timeout), .check_en(check_en), .exp_addr(exp_addr), .exp_data(exp_data),
    .irq_at(irq_at), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .interrupts(interrupts), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .hits(hits), .cycle_count(cycle_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: run phase as a small integer, cycle count as a plain
  // number, and for each interrupt line the number of high cycles remaining.
  localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;
  int              m_state;
  logic [NC-1:0]   m_hits;
  longint unsigned m_cnt;
  int              m_left[NI];

  function automatic logic [31:0] ea(input int i);
    return exp_addr[32*i +: 32];
  endfunction
  function automatic logic [31:0] ed(input int i);
    return exp_data[32*i +: 32];
  endfunction
  function automatic logic [CW-1:0] ia(input int i);
    return irq_at[CW*i +: CW];
  endfunction

  task automatic model_clear_irq();
    foreach (m_left[i]) m_left[i] = 0;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    int nxt, ptr, n_addr, n_both;
    logic [NC-1:0] hn;
    bit err;
    if (reset) begin
      m_state = M_IDLE; m_hits = '0; m_cnt = 0; model_clear_irq();
      return;
    end
    if (start) begin
      m_state = M_RUN; m_hits = '0; m_cnt = 0; model_clear_irq();
      return;
    end
    if (m_state != M_RUN) begin
      model_clear_irq();
      return;
    end
    hn = m_hits; err = 0; n_addr = 0; n_both = 0;
    if (memwrite) begin
      if (!mode_any) begin
        ptr = -1;
        for (int i = 0; i < NC; i++)
          if (check_en[i] && !m_hits[i]) begin ptr = i; break; end
        if (ptr >= 0 && dataadr == ea(ptr)) begin
          if (writedata == ed(ptr)) hn[ptr] = 1'b1;
          else err = 1;
        end
      end else begin
        for (int i = 0; i < NC; i++)
          if (check_en[i] && !m_hits[i] && dataadr == ea(i)) begin
            n_addr++;
            if (writedata == ed(i)) begin n_both++; hn[i] = 1'b1; end
          end
        err = (n_addr > 0) && (n_both == 0);
      end
    end
    if (&(hn | ~check_en))                 nxt = M_PASS;
    else if (strict && err)                nxt = M_FAIL;
    else if (timeout != 0 && m_cnt == timeout) nxt = M_FAIL;
    else                                   nxt = M_RUN;
    m_hits = hn;
    if (nxt == M_RUN) begin
      for (int i = 0; i < NI; i++) begin
        if (ia(i) != 0 && m_cnt == ia(i)) m_left[i] = IW;
        else if (m_left[i] > 0)           m_left[i]--;
      end
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      model_clear_irq();
    end
    m_state = nxt;
  endtask

  task automatic check_model(input string tag);
    logic [NI-1:0] ei;
    for (int i = 0; i < NI; i++) ei[i] = (m_left[i] > 0);
    n_tests++;
    if (interrupts !== ei || busy !== (m_state == M_RUN) || done !== (m_state >= M_PASS) ||
        pass !== (m_state == M_PASS) || fail !== (m_state == M_FAIL) ||
        hits !== m_hits || cycle_count !== CW'(m_cnt)) begin
      n_fail++;
      $display("FAIL model/%s: got b%0b d%0b p%0b f%0b hits=%b cnt=%0d irq=%b ; want state=%0d hits=%b cnt=%0d irq=%b",
               tag, busy, done, pass, fail, hits, cycle_count, interrupts, m_state, m_hits, m_cnt, ei);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One clock: model sees the applied inputs, then the DUT is sampled 1ns after the edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge ph1);
    #1;
    check_model(tag);
  endtask

  task automatic do_start();
    start = 1'b1; step("start"); start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    step("wr");
    memwrite = 1'b0;
  endtask

  task automatic set_table();
    exp_addr = '0; exp_data = '0;
    exp_addr[0*32 +: 32] = 32'h14; exp_data[0*32 +: 32] = 32'd21;
    exp_addr[1*32 +: 32] = 32'h18; exp_data[1*32 +: 32] = 32'd7;
    exp_addr[2*32 +: 32] = 32'h20; exp_data[2*32 +: 32] = 32'hAA;
    exp_addr[3*32 +: 32] = 32'h24; exp_data[3*32 +: 32] = 32'hBB;
  endtask

  typedef struct {
    logic        any;
    logic        strict;
    logic [3:0]  en;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  ehits;
    logic        epass;
    logic        efail;
  } vec_t;

  function automatic vec_t mkv(input logic a, input logic s, input logic [3:0] en,
                               input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] eh, input logic ep, input logic ef);
    vec_t v;
    v.any = a; v.strict = s; v.en = en; v.adr = adr; v.dat = dat;
    v.ehits = eh; v.epass = ep; v.efail = ef;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    // Single write after a fresh start, table entries (14,21)(18,7)(20,AA)(24,BB).
    vecs[0] = mkv(1'b0, 1'b0, 4'b0011, 32'h14, 32'd21,   4'b0001, 1'b0, 1'b0);
    vecs[1] = mkv(1'b0, 1'b0, 4'b0011, 32'h18, 32'd7,    4'b0000, 1'b0, 1'b0);
    vecs[2] = mkv(1'b0, 1'b1, 4'b0011, 32'h14, 32'd22,   4'b0000, 1'b0, 1'b1);
    vecs[3] = mkv(1'b0, 1'b1, 4'b0011, 32'h18, 32'd8,    4'b0000, 1'b0, 1'b0);
    vecs[4] = mkv(1'b1, 1'b0, 4'b0011, 32'h18, 32'd7,    4'b0010, 1'b0, 1'b0);
    vecs[5] = mkv(1'b1, 1'b1, 4'b0011, 32'h18, 32'd8,    4'b0000, 1'b0, 1'b1);
    vecs[6] = mkv(1'b0, 1'b0, 4'b0001, 32'h14, 32'd21,   4'b0001, 1'b1, 1'b0);
    vecs[7] = mkv(1'b0, 1'b0, 4'b0010, 32'h18, 32'd7,    4'b0010, 1'b1, 1'b0);
    vecs[8] = mkv(1'b1, 1'b1, 4'b1100, 32'h20, 32'hAA,   4'b0100, 1'b0, 1'b0);
    vecs[9] = mkv(1'b0, 1'b1, 4'b0000, 32'h00, 32'h0,    4'b0000, 1'b1, 1'b0);

    reset = 1'b1; start = 1'b0; mode_any = 1'b0; strict = 1'b0; memwrite = 1'b0;
    timeout = '0; check_en = '0; irq_at = '0; dataadr = '0; writedata = '0;
    set_table();
    m_state = M_IDLE; m_hits = '0; m_cnt = 0; model_clear_irq();

    step("rst"); step("rst");
    reset = 1'b0;
    step("idle");
    chk("reset_outputs", {interrupts, busy, done, pass, fail, hits, cycle_count}, 64'h0);

    // ---- table vectors ----
    for (int k = 0; k < 10; k++) begin
      mode_any = vecs[k].any; strict = vecs[k].strict; check_en = vecs[k].en;
      timeout = '0; irq_at = '0;
      do_start();
      wr(vecs[k].adr, vecs[k].dat);
      chk($sformatf("vec%0d_hits", k), hits, vecs[k].ehits);
      chk($sformatf("vec%0d_pass_fail", k), {pass, fail}, {vecs[k].epass, vecs[k].efail});
    end

    // ---- 1: ordered, one ignored write then both entries ----
    mode_any = 1'b0; strict = 1'b0; check_en = 4'b0011; timeout = '0; irq_at = '0;
    do_start();
    wr(32'h10, 32'd5);
    wr(32'h14, 32'd21);
    chk("t1_not_yet", pass, 1'b0);
    wr(32'h18, 32'd7);
    chk("t1_pass", {pass, fail}, 2'b10);
    chk("t1_hits", hits, 4'b0011);

    // ---- 2: ordered, reversed writes, timeout at 100 ----
    timeout = 32'd100;
    do_start();
    wr(32'h18, 32'd7);
    wr(32'h14, 32'd21);
    for (int k = 0; k < 200 && !done; k++) step("t2");
    chk("t2_fail", {pass, fail}, 2'b01);
    chk("t2_hits", hits, 4'b0001);
    chk("t2_cycle_count", cycle_count, 64'd100);

    // ---- 3: any-order, reversed writes ----
    mode_any = 1'b1; timeout = '0;
    do_start();
    wr(32'h18, 32'd7);
    chk("t3_after_first", {pass, hits}, {1'b0, 4'b0010});
    wr(32'h14, 32'd21);
    chk("t3_pass", {pass, fail}, 2'b10);

    // ---- 4: strict wrong data, then same write non-strict ----
    mode_any = 1'b0; strict = 1'b1;
    do_start();
    wr(32'h14, 32'd22);
    chk("t4_strict_fail", {fail, hits}, {1'b1, 4'b0000});
    strict = 1'b0;
    do_start();
    wr(32'h14, 32'd22);
    step("t4b");
    chk("t4_nonstrict", {busy, fail}, 2'b10);

    // ---- 5: interrupt pulse on line 1 at cycle 10 ----
    irq_at = '0; irq_at[1*CW +: CW] = 32'd10; check_en = 4'b0011;
    do_start();
    for (int k = 0; k < 30 && cycle_count < 20; k++) begin
      step("t5a");
      chk($sformatf("t5_irq_cnt%0d", cycle_count), interrupts,
          (cycle_count >= 11 && cycle_count <= 15) ? 64'h02 : 64'h00);
    end
    chk("t5_reached20", cycle_count, 64'd20);
    do_start();
    wr(32'h14, 32'd21);
    for (int k = 0; k < 30 && cycle_count != 12; k++) step("t5b");
    chk("t5_irq_at12", interrupts, 64'h02);
    wr(32'h18, 32'd7);
    chk("t5_pass_irq_clear", {pass, interrupts}, {1'b1, 8'h00});

    // ---- 6: reset mid-pulse, then restart mid-run ----
    do_start();
    wr(32'h14, 32'd21);
    for (int k = 0; k < 30 && cycle_count != 12; k++) step("t6a");
    chk("t6_pulse_active", interrupts[1], 1'b1);
    reset = 1'b1; step("t6_rst"); reset = 1'b0;
    chk("t6_after_reset", {interrupts, busy, done, pass, fail, hits, cycle_count}, 64'h0);
    do_start();
    wr(32'h14, 32'd21);
    chk("t6_hits01", hits, 4'b0001);
    do_start();
    chk("t6_restart", {busy, hits, cycle_count}, {1'b1, 4'b0000, 32'd0});

    // ---- randomized runs against the model ----
    for (int r = 0; r < 40; r++) begin
      mode_any = 1'($urandom_range(0, 1));
      strict   = 1'($urandom_range(0, 1));
      check_en = NC'($urandom);
      for (int i = 0; i < NC; i++) begin
        exp_addr[32*i +: 32] = 32'($urandom_range(0, 5)) * 32'd4;
        exp_data[32*i +: 32] = 32'($urandom_range(0, 3));
      end
      timeout = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom_range(15, 60));
      for (int i = 0; i < NI; i++)
        irq_at[CW*i +: CW] = ($urandom_range(0, 1) == 0) ? '0 : CW'($urandom_range(1, 40));
      start = 1'b1; step("rnd_start"); start = 1'b0;
      for (int c = 0; c < 70; c++) begin
        int e;
        memwrite = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 0) begin
          e = int'($urandom_range(0, NC - 1));
          dataadr   = ea(e);
          writedata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : ed(e);
        end else begin
          dataadr   = 32'($urandom_range(0, 5)) * 32'd4;
          writedata = 32'($urandom_range(0, 3));
        end
        reset = ($urandom_range(0, 150) == 0);
        start = ($urandom_range(0, 80) == 0);
        step("rnd");
      end
      reset = 1'b0; start = 1'b0; memwrite = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
